ps2_interface: RTL and testbench

PS2_INTERFACE -- requirements
Module: ps2_interface

---
 rtl/ps2_interface.sv | 141 ++++++++++++++
 tb/tb_ps2_interface.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ps2_interface.sv
// ps2_interface: PS/2 host controller with filtered lines, frame receive and host-to-device transmit
module ps2_interface #(
   parameter int DEBOUNCE       = 8,
   parameter int HOLD_CYCLES    = 10000,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire        ps2_clk,
   inout  wire        ps2_data,
   output logic [7:0] rx_data,
   output logic       read_data,
   input  logic [7:0] tx_data,
   input  logic       write_data,
   output logic       busy,
   output logic       err
);
   localparam int DW   = $clog2(DEBOUNCE + 1);
   localparam int TMAX = HOLD_CYCLES > TIMEOUT_CYCLES ? HOLD_CYCLES : TIMEOUT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   typedef enum logic [2:0] {IDLE, RX, TX_INHIBIT, TX_START, TX_BITS, TX_ACK} state_t;
   state_t        state_q, state_d;
   logic [1:0]    meta_q, sync_q;
   logic          fclk_q, fclk_d, fdat_q, fdat_d, prev_q;
   logic [DW-1:0] dclk_q, dclk_d, ddat_q, ddat_d;
   logic [3:0]    bit_q, bit_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [8:0]    rsh_q, rsh_d;
   logic [9:0]    tsh_q, tsh_d;
   logic [7:0]    rx_q, rx_d;
   logic          read_q, read_d, err_q, err_d;
   logic          fall, clk_low, dat_low;
   function automatic logic [DW:0] filt_next(input logic s, input logic f, input logic [DW-1:0] c);
      if (s == f) return {f, DW'(0)};
      if (c == DW'(DEBOUNCE - 1)) return {s, DW'(0)};
      return {f, c + DW'(1)};
   endfunction
   assign {fclk_d, dclk_d} = filt_next(sync_q[0], fclk_q, dclk_q);
   assign {fdat_d, ddat_d} = filt_next(sync_q[1], fdat_q, ddat_q);
   assign fall      = prev_q & ~fclk_q;
   assign clk_low   = state_q == TX_INHIBIT;
   assign dat_low   = state_q == TX_START || (state_q == TX_BITS && !tsh_q[0]);
   assign ps2_clk   = clk_low ? 1'b0 : 1'bz;
   assign ps2_data  = dat_low ? 1'b0 : 1'bz;
   assign rx_data   = rx_q;
   assign read_data = read_q;
   assign err       = err_q;
   assign busy      = state_q != IDLE;
   // protocol sequencing: frame receive, transmit handshake and inter-edge timeout
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      tmr_d   = fall ? '0 : tmr_q + TW'(1);
      rsh_d   = rsh_q;
      tsh_d   = tsh_q;
      rx_d    = rx_q;
      read_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            tmr_d = '0;
            bit_d = '0;
            if (fall && !fdat_q) state_d = RX;
            else if (write_data) begin
               tsh_d   = {1'b1, ~^tx_data, tx_data};
               state_d = TX_INHIBIT;
            end
         end
         RX: if (fall) begin
            if (bit_q == 4'd9) begin
               state_d = IDLE;
               if (fdat_q && ^rsh_q) begin
                  rx_d   = rsh_q[7:0];
                  read_d = 1'b1;
               end else err_d = 1'b1;
            end else begin
               rsh_d = {fdat_q, rsh_q[8:1]};
               bit_d = bit_q + 4'd1;
            end
         end
         TX_INHIBIT: begin
            tmr_d = tmr_q + TW'(1);
            if (tmr_q == TW'(HOLD_CYCLES - 1)) begin
               tmr_d   = '0;
               state_d = TX_START;
            end
         end
         TX_START: if (fall) state_d = TX_BITS;
         TX_BITS: if (fall) begin
            tsh_d = {1'b1, tsh_q[9:1]};
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd8) state_d = TX_ACK;
         end
         TX_ACK: if (fall) begin
            state_d = IDLE;
            err_d   = fdat_q;
         end
         default: state_d = IDLE;
      endcase
      if (state_q inside {RX, TX_START, TX_BITS, TX_ACK} && !fall && tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end
   // line synchronizers, debounce filters and protocol state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q  <= 2'b11;
         sync_q  <= 2'b11;
         fclk_q  <= 1'b1;
         fdat_q  <= 1'b1;
         prev_q  <= 1'b1;
         dclk_q  <= '0;
         ddat_q  <= '0;
         state_q <= IDLE;
         bit_q   <= '0;
         tmr_q   <= '0;
         rsh_q   <= '0;
         tsh_q   <= '0;
         rx_q    <= '0;
         read_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         meta_q  <= {ps2_data, ps2_clk};
         sync_q  <= meta_q;
         fclk_q  <= fclk_d;
         fdat_q  <= fdat_d;
         prev_q  <= fclk_q;
         dclk_q  <= dclk_d;
         ddat_q  <= ddat_d;
         state_q <= state_d;
         bit_q   <= bit_d;
         tmr_q   <= tmr_d;
         rsh_q   <= rsh_d;
         tsh_q   <= tsh_d;
         rx_q    <= rx_d;
         read_q  <= read_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_ps2_interface.sv
// tb_ps2_interface: randomized PS/2 device model checking the host controller against expected frames
module tb_ps2_interface;
   localparam int D = 4, H = 40, T = 400, HALF = 10;
   logic       clk = 1'b0, rst = 1'b1;
   logic [7:0] tx_data = '0, rx_data;
   logic       write_data = 1'b0, read_data, busy, err;
   logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
   wire        ps2_clk, ps2_data;
   int         n_chk = 0, n_err = 0, rd_n = 0, er_n = 0;
   logic [7:0] exp_rx = '0;
   pullup (ps2_clk);
   pullup (ps2_data);
   assign ps2_clk  = dev_clk_low ? 1'b0 : 1'bz;
   assign ps2_data = dev_dat_low ? 1'b0 : 1'bz;
   ps2_interface #(.DEBOUNCE(D), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx_data(rx_data),
      .read_data(read_data), .tx_data(tx_data), .write_data(write_data), .busy(busy), .err(err)
   );
   always #5 clk = ~clk;
   // pulse-cycle counters for read_data and err
   always @(posedge clk) begin
      rd_n <= rd_n + int'(read_data);
      er_n <= er_n + int'(err);
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic dev_bit(input logic b);
      dev_dat_low = !b;
      wait_n(HALF);
      dev_clk_low = 1'b1;
      wait_n(HALF);
      dev_clk_low = 1'b0;
   endtask
   task automatic rx_case(input string tag, input logic [7:0] b, input logic par, input logic stop);
      int r0, e0;
      logic good;
      r0 = rd_n;
      e0 = er_n;
      good = stop && ^{b, par};
      dev_bit(1'b0);
      for (int i = 0; i < 8; i++) dev_bit(b[i]);
      dev_bit(par);
      dev_bit(stop);
      dev_dat_low = 1'b0;
      wait_n(2 * HALF);
      if (good) exp_rx = b;
      check({tag, "_rd"}, rd_n - r0, good ? 1 : 0);
      check({tag, "_err"}, er_n - e0, good ? 0 : 1);
      check({tag, "_rx"}, rx_data, exp_rx);
      check({tag, "_busy"}, busy, 0);
   endtask
   task automatic tx_case(input string tag, input logic [7:0] b, input logic ack);
      int r0, e0, w, lo;
      logic [9:0] got;
      r0 = rd_n;
      e0 = er_n;
      tx_data = b;
      write_data = 1'b1;
      @(negedge clk);
      write_data = 1'b0;
      w = 0;
      while (ps2_clk !== 1'b0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      lo = 0;
      while (ps2_clk === 1'b0 && lo < H + 50) begin
         lo++;
         @(negedge clk);
      end
      check({tag, "_hold"}, lo, H);
      check({tag, "_start"}, ps2_data, 0);
      wait_n(HALF);
      for (int i = 0; i < 10; i++) begin
         dev_clk_low = 1'b1;
         wait_n(HALF);
         got[i] = ps2_data;
         dev_clk_low = 1'b0;
         wait_n(HALF);
      end
      check({tag, "_bits"}, got, {1'b1, ~^b, b});
      dev_dat_low = ack;
      wait_n(2);
      dev_clk_low = 1'b1;
      wait_n(HALF);
      dev_clk_low = 1'b0;
      wait_n(HALF);
      dev_dat_low = 1'b0;
      wait_n(HALF);
      check({tag, "_err"}, er_n - e0, ack ? 0 : 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_rd"}, rd_n - r0, 0);
   endtask
   initial begin
      int r0, e0, cnt;
      logic [7:0] b;
      wait_n(5);
      check("rst_rx", rx_data, 0);
      check("rst_rd", read_data, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      wait_n(5);
      check("idle_clk", ps2_clk, 1);
      check("idle_dat", ps2_data, 1);
      rx_case("rx1c", 8'h1C, 1'b0, 1'b1);
      rx_case("rxf0", 8'hF0, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         int kind;
         b = 8'($urandom);
         kind = $urandom_range(0, 3);
         rx_case("rxrnd", b, kind == 0 ? ^b : ~^b, kind != 1);
      end
      tx_case("txed", 8'hED, 1'b1);
      for (int k = 0; k < 4; k++) tx_case("txrnd", 8'($urandom), 1'($urandom_range(0, 1)));
      r0 = rd_n;
      e0 = er_n;
      dev_bit(1'b0);
      for (int i = 0; i < 4; i++) dev_bit(1'($urandom));
      dev_dat_low = 1'b0;
      cnt = 0;
      while (er_n == e0 && cnt < T + 100) begin
         @(negedge clk);
         cnt++;
      end
      check("to_time", (cnt >= T - 20 && cnt <= T + 20) ? 1 : 0, 1);
      wait_n(3);
      check("to_err", er_n - e0, 1);
      check("to_rd", rd_n - r0, 0);
      check("to_busy", busy, 0);
      rx_case("rx55", 8'h55, 1'b1, 1'b1);
      r0 = rd_n;
      e0 = er_n;
      dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      wait_n(D - 1);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) break;
      end
      check("glitch_busy", busy, 0);
      check("glitch_pulses", (rd_n - r0) + (er_n - e0), 0);
      r0 = rd_n;
      e0 = er_n;
      dev_bit(1'b0);
      for (int i = 0; i < 3; i++) dev_bit(1'b1);
      check("mid_busy", busy, 1);
      rst = 1'b1;
      dev_dat_low = 1'b0;
      wait_n(2);
      exp_rx = '0;
      check("mrst_rx", rx_data, exp_rx);
      check("mrst_busy", busy, 0);
      check("mrst_rd", read_data, 0);
      check("mrst_err", err, 0);
      check("mrst_lines", {ps2_clk, ps2_data}, 2'b11);
      rst = 1'b0;
      wait_n(20);
      check("mrst_pulses", (rd_n - r0) + (er_n - e0), 0);
      rx_case("rxpost", 8'hA7, ~^8'hA7, 1'b1);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
